pipe_trace_buffer: RTL

//  Synthesizable multi-channel pipeline trace recorder for the venus core.

---
 rtl/pipe_trace_buffer_pkg.sv | 22 ++
 rtl/pipe_trace_buffer_ram.sv | 37 +++
 rtl/pipe_trace_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the venus pipeline trace recorder.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds a per-entry cycle timestamp).
package pipe_trace_buffer_pkg;

    // Recorder states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } tr_state_e;

    // Width of one stored entry: valid mask, payloads and (optionally) timestamp.
    function automatic int entry_width(input int nch, input int w, input int tsw);
`ifdef TRACE_TIMESTAMP_EN
        return nch + nch * w + tsw;
`else
        return nch + nch * w + (tsw - tsw);
`endif
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Trace storage: DEPTH x EW single-write single-read RAM with a registered
// read port, giving the one-cycle request-to-ack latency of the read port.
module pipe_trace_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int EW    = 132
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [EW-1:0]            wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [EW-1:0]            rd_data_o
);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] rd_data_q;

    // Write port.
    // NOTE: the array has no reset; a reset would force flops instead of RAM macros, and
    // the top never exposes an entry that has not been written since arm.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Multi-channel pipeline trace recorder: ring capture, PC-match trigger with
// post-trigger count, freeze, and oldest-first readback through req/ack.
// Optional feature macro: TRACE_TIMESTAMP_EN (free-running timestamp per entry).
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 16,
    parameter int TSW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm_i,
    input  logic                       trig_en_i,
    input  logic [AW-1:0]              trig_addr_i,
    input  logic [$clog2(DEPTH):0]     post_cnt_i,
    input  logic                       pc_v_i,
    input  logic [AW-1:0]              pc_i,
    input  logic [NCH-1:0]             ch_v_i,
    input  logic [NCH*W-1:0]           ch_data_i,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    input  logic                       rd_req_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic                       rd_ack_o,
    output logic [NCH-1:0]             rd_vmask_o,
    output logic [NCH*W-1:0]           rd_data_o,
    output logic [TSW-1:0]             rd_ts_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = NCH * W;
    localparam int EW = entry_width(NCH, W, TSW);

    tr_state_e       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   post_q, post_d;
    logic            ack_q, ack_d;
    logic            rd_valid_q, rd_valid_d;

    logic            cap_en;
    logic            trig;
    logic            wr_en;
    logic            rd_fire;
    logic            rd_oob;
    logic [PW-1:0]   rd_addr;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   rd_entry;

    // Trigger only counts while armed; arm in the same cycle cancels any write.
    assign trig    = trig_en_i & pc_v_i & (pc_i == trig_addr_i) & (state_q == TR_ARMED);
    assign wr_en   = cap_en & ((|ch_v_i) | trig) & ~arm_i;
    assign rd_fire = rd_req_i & (state_q == TR_DONE) & ~arm_i;
    assign rd_oob  = {1'b0, rd_idx_i} >= count_q;
    // Oldest held entry sits count entries behind the write pointer.
    assign rd_addr = wr_ptr_q - count_q[PW-1:0] + rd_idx_i;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= TR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: arm overrides everything, trigger and post count drive the rest.
    // NOTE: each combinational block assigns a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = TR_ARMED;
        end else begin
            unique case (state_q)
                TR_IDLE:  state_d = TR_IDLE;
                TR_ARMED: if (trig) state_d = (post_cnt_i != '0) ? TR_POST : TR_DONE;
                TR_POST:  if (wr_en && post_q == CW'(1)) state_d = TR_DONE;
                TR_DONE:  state_d = TR_DONE;
                default:  state_d = TR_IDLE;
            endcase
        end
    end

    // FSM outputs: capture window and visible state.
    always_comb begin
        cap_en  = (state_q == TR_ARMED) || (state_q == TR_POST);
        state_o = state_q;
    end

    // Pointer, count, overflow, post counter and read-port control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            post_q     <= '0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            post_q     <= post_d;
            ack_q      <= ack_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next values for pointers and counters; arm clears the buffer and read outputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        post_d     = post_q;
        ack_d      = rd_fire;
        rd_valid_d = rd_fire ? ~rd_oob : rd_valid_q;
        if (arm_i) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            post_d     = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q == CW'(DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
                if (state_q == TR_POST) begin
                    post_d = post_q - 1'b1;
                end
            end
            if (trig) begin
                post_d = post_cnt_i;
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TSW-1:0] ts_q;

    // Free-running cycle counter stamped into every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wr_entry = {ts_q, ch_v_i, ch_data_i};
    assign rd_ts_o  = rd_valid_q ? rd_entry[EW-1 -: TSW] : '0;
`else
    assign wr_entry = {ch_v_i, ch_data_i};
    assign rd_ts_o  = '0;
`endif

    pipe_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_en_i   (rd_fire & ~rd_oob),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_entry)
    );

    // Read outputs read as zero after reset, arm, or an out-of-range ack.
    assign rd_ack_o   = ack_q;
    assign rd_vmask_o = rd_valid_q ? rd_entry[DW +: NCH] : '0;
    assign rd_data_o  = rd_valid_q ? rd_entry[DW-1:0] : '0;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule
